data_mem_responder: RTL and testbench
=====================================

Name: data_mem_responder

Overview:
Data-side memory responder for the fault-tolerant SoC. Answers the core's data-bus requests (req/gnt/rvalid, one outstanding transaction) with a byte-enabled word RAM plus two memory-mapped status registers. The registers drive mem_flag_o and mem_result_o, the SoC-level completion flag and result. Programmable grant wait states let benches stress core stall paths during error injection and recovery.

Parameters:
DEPTH_WORDS, 256, RAM size in 32-bit words; byte range 0 .. 4*DEPTH_WORDS-1
WAIT_STATES, 0, cycles between req rising and gnt (0..15)
FLAG_ADDR, 32'h0000_1000, byte address of the flag register
RESULT_ADDR, 32'h0000_1004, byte address of the result register
BAD_RDATA, 32'hDEAD_BEEF, read data returned for unmapped addresses

Ports:
clk_i  in  1  clock, rising edge
rst_i  in  1  synchronous reset, active-high
data_req_i  in  1  core request valid
data_gnt_o  out  1  request accepted this cycle
data_rvalid_o  out  1  response valid, exactly one per grant
data_we_i  in  1  1 = write, 0 = read
data_be_i  in  4  byte enables, bit n covers wdata[8n+7:8n]
data_addr_i  in  32  byte address; bits [1:0] ignored
data_wdata_i  in  32  write data
data_rdata_o  out  32  read data, valid with rvalid
data_err_o  out  1  unmapped-address pulse, coincident with rvalid
mem_flag_o  out  32  flag register contents
mem_result_o  out  32  result register contents

Behaviour:
- Reset (rst_i high at a clock edge): state IDLE, wait counter 0, data_gnt_o 0, data_rvalid_o 0, data_rdata_o 0, data_err_o 0, mem_flag_o 0, mem_result_o 0. RAM contents are not reset.
- FSM states: IDLE, WAIT.
- IDLE, req=1, WAIT_STATES=0: data_gnt_o=1 combinationally in the same cycle; state stays IDLE.
- IDLE, req=1, WAIT_STATES>0: go to WAIT with counter=1, no grant.
- WAIT, req=1, counter<WAIT_STATES: counter increments each cycle.
- WAIT, req=1, counter==WAIT_STATES: data_gnt_o=1 combinationally; return to IDLE; counter cleared.
- WAIT, req=0 (core withdrew): return to IDLE, counter cleared, no grant, no response.
- data_gnt_o never asserts when req=0 or during reset.
- Request fields (we, be, addr, wdata) are sampled only in the grant cycle.
- Write effects are visible from the next cycle.
- data_rvalid_o is high exactly one cycle after each grant, for one cycle.
- data_rdata_o holds its value after rvalid until the next response.
- Back-to-back: a new grant may occur in the same cycle as the previous rvalid. Full throughput is one transaction per clock when WAIT_STATES=0.
- Address decode, word address = addr[31:2]:
  - Word address < DEPTH_WORDS: RAM.
  - addr[31:2]==FLAG_ADDR[31:2]: flag register.
  - addr[31:2]==RESULT_ADDR[31:2]: result register.
  - Anything else: unmapped.
- Writes update only bytes with be=1. be=0000 is a granted no-op with normal rvalid. Write response rdata is 0.
- Reads return the full word regardless of be. Unmapped reads return BAD_RDATA with data_err_o=1.
- Unmapped writes are discarded; data_err_o=1 with rvalid.
- A read in the cycle after a write to the same address returns the newly written data.
- Reset mid-transaction: rst_i high on the edge after a grant suppresses that response (rvalid stays 0). A pending WAIT count is discarded.
- mem_flag_o and mem_result_o change only on granted writes or reset. They are registered: they update on the edge after the grant, the same edge that raises rvalid.

Test Plan:
1. WAIT_STATES=0; write 0x0000_0037 to addr 0x10 (be=1111), then read 0x10 -> gnt in the req cycle each time; rvalid the following cycle; rdata=0x0000_0037; err=0.
2. Write 0xAABBCCDD to 0x20 be=1111, then 0x11223344 be=0101, then read -> rdata=0xAA22CC44.
3. Write 0x0000_0001 to FLAG_ADDR, 0x0000_0037 to RESULT_ADDR -> mem_result_o=55 one edge after its grant; mem_flag_o=1 one edge after its grant; readback matches both.
4. WAIT_STATES=3; hold req from cycle 0 -> gnt in cycle 3, rvalid in cycle 4. Second run with req dropped in cycle 2 -> no gnt, no rvalid; next req restarts the count at 1.
5. Read 0x0000_2000 -> rvalid with rdata=0xDEADBEEF, err=1. Write 0x0000_2000 -> err=1; no RAM or register contents change.
6. Grant a read, assert rst_i on the next edge -> no rvalid; mem_flag_o=0; mem_result_o=0; RAM word written before reset still reads back correctly.

Source files
------------

// File: rtl/data_mem_responder.sv
// Data-side memory responder: a req/gnt/rvalid slave with a byte-enabled
// word RAM, plus flag and result registers that are mapped into the
// address space. Grants can be delayed by a fixed number of wait states.
module data_mem_responder #(
    parameter int unsigned DEPTH_WORDS = 256,
    parameter int unsigned WAIT_STATES = 0,
    parameter logic [31:0] FLAG_ADDR   = 32'h0000_1000,
    parameter logic [31:0] RESULT_ADDR = 32'h0000_1004,
    parameter logic [31:0] BAD_RDATA   = 32'hDEAD_BEEF
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        data_req_i,
    output logic        data_gnt_o,
    output logic        data_rvalid_o,
    input  logic        data_we_i,
    input  logic [3:0]  data_be_i,
    input  logic [31:0] data_addr_i,
    input  logic [31:0] data_wdata_i,
    output logic [31:0] data_rdata_o,
    output logic        data_err_o,
    output logic [31:0] mem_flag_o,
    output logic [31:0] mem_result_o
);

    localparam int unsigned AW      = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [3:0]  WS      = WAIT_STATES[3:0];
    localparam logic [29:0] DEPTH_W = 30'(DEPTH_WORDS);

    typedef enum logic {IDLE, WAIT} state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;

    logic [31:0] ram [DEPTH_WORDS];

    logic [29:0]   word_addr;
    logic [AW-1:0] ram_idx;
    logic          hit_ram, hit_flag, hit_result, unmapped;
    logic [31:0]   rd_word;
    logic          unused_addr_lsbs;

    // Byte lanes with be=1 take the new data, the rest keep the old word.
    function automatic logic [31:0] merge_be(input logic [31:0] old_w,
                                             input logic [31:0] new_w,
                                             input logic [3:0]  be);
        logic [31:0] res;
        res = old_w;
        for (int b = 0; b < 4; b++) begin
            if (be[b]) res[8*b +: 8] = new_w[8*b +: 8];
        end
        return res;
    endfunction

    // Word-granular address decode; RAM takes priority over the registers.
    always_comb begin
        word_addr        = data_addr_i[31:2];
        ram_idx          = data_addr_i[AW+1:2];
        unused_addr_lsbs = ^data_addr_i[1:0];
        hit_ram          = (word_addr < DEPTH_W);
        hit_flag         = !hit_ram && (word_addr == FLAG_ADDR[31:2]);
        hit_result       = !hit_ram && !hit_flag && (word_addr == RESULT_ADDR[31:2]);
        unmapped         = !(hit_ram || hit_flag || hit_result);
        rd_word          = BAD_RDATA;
        if (hit_ram)         rd_word = ram[ram_idx];
        else if (hit_flag)   rd_word = mem_flag_o;
        else if (hit_result) rd_word = mem_result_o;
    end

    // Grant FSM state and wait-state counter.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Grant decision: immediate with no wait states, otherwise after the
    // count reaches WAIT_STATES while req is held; a withdrawn req restarts.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        data_gnt_o = 1'b0;
        case (state_q)
            IDLE: begin
                if (data_req_i) begin
                    if (WS == 4'd0) begin
                        data_gnt_o = 1'b1;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = 4'd1;
                    end
                end
            end
            WAIT: begin
                if (!data_req_i) begin
                    state_d = IDLE;
                    cnt_d   = 4'd0;
                end else if (cnt_q == WS) begin
                    data_gnt_o = 1'b1;
                    state_d    = IDLE;
                    cnt_d      = 4'd0;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = 4'd0;
            end
        endcase
        // A reset edge cancels the transaction, so never grant into it.
        if (rst_i) data_gnt_o = 1'b0;
    end

    // RAM byte writes on granted in-range writes; contents survive reset.
    always_ff @(posedge clk_i) begin
        if (data_gnt_o && data_we_i && hit_ram) begin
            for (int b = 0; b < 4; b++) begin
                if (data_be_i[b]) ram[ram_idx][8*b +: 8] <= data_wdata_i[8*b +: 8];
            end
        end
    end

    // Response and status registers, all updated on the edge after grant.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            data_rvalid_o <= 1'b0;
            data_rdata_o  <= 32'd0;
            data_err_o    <= 1'b0;
            mem_flag_o    <= 32'd0;
            mem_result_o  <= 32'd0;
        end else begin
            data_rvalid_o <= data_gnt_o;
            if (data_gnt_o) begin
                data_rdata_o <= data_we_i ? 32'd0 : rd_word;
                data_err_o   <= unmapped;
                if (data_we_i && hit_flag)
                    mem_flag_o <= merge_be(mem_flag_o, data_wdata_i, data_be_i);
                if (data_we_i && hit_result)
                    mem_result_o <= merge_be(mem_result_o, data_wdata_i, data_be_i);
            end else begin
                data_err_o <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_data_mem_responder.sv
// Randomized scoreboard bench for data_mem_responder. Accepted requests are
// turned into expected responses by an address-map model; a monitor pops
// and compares whenever rvalid is seen. A second instance with three wait
// states gets directed grant-timing checks.
module tb_data_mem_responder;

    localparam int          DEPTH = 256;
    localparam logic [31:0] FLAG  = 32'h0000_1000;
    localparam logic [31:0] RES   = 32'h0000_1004;
    localparam logic [31:0] BAD   = 32'hDEAD_BEEF;

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic        req0 = 1'b0, we0 = 1'b0;
    logic [3:0]  be0 = 4'd0;
    logic [31:0] addr0 = 32'd0, wdata0 = 32'd0;
    logic        gnt0, rvalid0, err0;
    logic [31:0] rdata0, flag0, res0;

    logic        req3 = 1'b0, we3 = 1'b0;
    logic [3:0]  be3 = 4'd0;
    logic [31:0] addr3 = 32'd0, wdata3 = 32'd0;
    logic        gnt3, rvalid3, err3;
    logic [31:0] rdata3, flag3, res3;

    always #5 clk = ~clk;

    data_mem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_STATES(0)) dut0 (
        .clk_i(clk), .rst_i(rst), .data_req_i(req0), .data_gnt_o(gnt0),
        .data_rvalid_o(rvalid0), .data_we_i(we0), .data_be_i(be0),
        .data_addr_i(addr0), .data_wdata_i(wdata0), .data_rdata_o(rdata0),
        .data_err_o(err0), .mem_flag_o(flag0), .mem_result_o(res0));

    data_mem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_STATES(3)) dut3 (
        .clk_i(clk), .rst_i(rst), .data_req_i(req3), .data_gnt_o(gnt3),
        .data_rvalid_o(rvalid3), .data_we_i(we3), .data_be_i(be3),
        .data_addr_i(addr3), .data_wdata_i(wdata3), .data_rdata_o(rdata3),
        .data_err_o(err3), .mem_flag_o(flag3), .mem_result_o(res3));

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        logic        known;
        int          cyc;
    } exp_t;

    exp_t        sbq[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    logic [31:0] m_ram [int];
    logic [31:0] m_flag = 32'd0, m_res = 32'd0, last_rdata = 32'd0;

    logic        c_v = 1'b0, c_we = 1'b0;
    logic [3:0]  c_be = 4'd0;
    logic [31:0] c_addr = 32'd0, c_wdata = 32'd0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // 0 = RAM, 1 = flag, 2 = result, 3 = unmapped
    function automatic int region(input logic [31:0] a);
        if ((a >> 2) < DEPTH)      return 0;
        if ((a >> 2) == (FLAG >> 2)) return 1;
        if ((a >> 2) == (RES >> 2))  return 2;
        return 3;
    endfunction

    function automatic logic [31:0] apply_be(input logic [31:0] o, input logic [31:0] n,
                                             input logic [3:0] be);
        logic [31:0] r;
        r = o;
        for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = n[8*b +: 8];
        return r;
    endfunction

    // Capture whatever handshake dut0 shows mid-cycle.
    initial forever begin
        @(negedge clk);
        c_v = req0 && gnt0;
        c_we = we0; c_be = be0; c_addr = addr0; c_wdata = wdata0;
    end

    // Commit accepted requests to the model at the clock edge (unless reset).
    initial forever begin
        exp_t e;
        int   r;
        int   w;
        @(posedge clk);
        cyc++;
        if (rst) begin
            m_flag = 32'd0; m_res = 32'd0; last_rdata = 32'd0;
        end else if (c_v) begin
            r = region(c_addr);
            w = int'(c_addr >> 2);
            e.cyc = cyc; e.known = 1'b1; e.err = (r == 3);
            if (c_we) begin
                e.rdata = 32'd0;
                if (r == 0) begin
                    if (m_ram.exists(w))     m_ram[w] = apply_be(m_ram[w], c_wdata, c_be);
                    else if (c_be == 4'hF)   m_ram[w] = c_wdata;
                end else if (r == 1) m_flag = apply_be(m_flag, c_wdata, c_be);
                else if (r == 2)     m_res  = apply_be(m_res, c_wdata, c_be);
            end else begin
                case (r)
                    0: begin
                        e.known = m_ram.exists(w);
                        e.rdata = e.known ? m_ram[w] : 32'd0;
                    end
                    1:       e.rdata = m_flag;
                    2:       e.rdata = m_res;
                    default: e.rdata = BAD;
                endcase
            end
            sbq.push_back(e);
        end
    end

    // Monitor: grant behaviour, response timing/content, rdata hold.
    initial forever begin
        exp_t e;
        @(negedge clk);
        if (!rst) begin
            chk("gnt0_follows_req", {31'd0, gnt0}, {31'd0, req0});
            if (sbq.size() > 0 && sbq[0].cyc < cyc) begin
                e = sbq.pop_front();
                chk("rvalid_missing_at_cycle", cyc, e.cyc);
            end
            if (rvalid0) begin
                if (sbq.size() == 0) begin
                    chk("spurious_rvalid", {31'd0, rvalid0}, 32'd0);
                end else begin
                    e = sbq.pop_front();
                    chk("rvalid_latency", cyc, e.cyc);
                    if (e.known) chk("rdata", rdata0, e.rdata);
                    chk("err", {31'd0, err0}, {31'd0, e.err});
                    chk("mem_flag", flag0, m_flag);
                    chk("mem_result", res0, m_res);
                    last_rdata = e.known ? e.rdata : rdata0;
                end
            end else begin
                chk("rdata_hold", rdata0, last_rdata);
                chk("err_idle", {31'd0, err0}, 32'd0);
            end
        end
    end

    task automatic drive(input logic r, input logic w, input logic [3:0] b,
                         input logic [31:0] a, input logic [31:0] d);
        @(posedge clk); #1;
        req0 = r; we0 = w; be0 = b; addr0 = a; wdata0 = d;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 4'd0, 32'd0, 32'd0);
    endtask

    // Issue a read, then check the response word directly against a constant.
    task automatic read_chk(input string name, input logic [31:0] a,
                            input logic [31:0] exp, input logic exp_err);
        drive(1'b1, 1'b0, 4'hF, a, 32'd0);
        idle();
        @(negedge clk);
        chk({name, "_rvalid"}, {31'd0, rvalid0}, 32'd1);
        chk({name, "_rdata"}, rdata0, exp);
        chk({name, "_err"}, {31'd0, err0}, {31'd0, exp_err});
    endtask

    task automatic drive3(input logic r, input logic w, input logic [31:0] a,
                          input logic [31:0] d);
        @(posedge clk); #1;
        req3 = r; we3 = w; be3 = 4'hF; addr3 = a; wdata3 = d;
    endtask

    // Hold req on dut3 and expect a grant exactly in cycle 3, rvalid in cycle 4.
    task automatic ws_run(input string name, input logic w, input logic [31:0] a,
                          input logic [31:0] d, input logic [31:0] exp_rdata);
        drive3(1'b1, w, a, d);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk({name, "_gnt_cycle"}, {31'd0, gnt3}, (k == 3) ? 32'd1 : 32'd0);
            if (k < 3) @(posedge clk);
        end
        drive3(1'b0, 1'b0, 32'd0, 32'd0);
        @(negedge clk);
        chk({name, "_rvalid"}, {31'd0, rvalid3}, 32'd1);
        chk({name, "_rdata"}, rdata3, exp_rdata);
        @(negedge clk);
        chk({name, "_rvalid_once"}, {31'd0, rvalid3}, 32'd0);
    endtask

    initial begin
        logic [31:0] a;
        logic [3:0]  b;
        int          sel;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_gnt0", {31'd0, gnt0}, 32'd0);
        chk("rst_rvalid0", {31'd0, rvalid0}, 32'd0);
        chk("rst_rdata0", rdata0, 32'd0);
        chk("rst_err0", {31'd0, err0}, 32'd0);
        chk("rst_flag0", flag0, 32'd0);
        chk("rst_result0", res0, 32'd0);
        chk("rst_rvalid3", {31'd0, rvalid3}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Basic write then read
        drive(1'b1, 1'b1, 4'hF, 32'h10, 32'h0000_0037);
        read_chk("t1_read", 32'h10, 32'h0000_0037, 1'b0);

        // Byte-enable merge
        drive(1'b1, 1'b1, 4'hF,   32'h20, 32'hAABB_CCDD);
        drive(1'b1, 1'b1, 4'b0101, 32'h20, 32'h1122_3344);
        read_chk("t2_be_merge", 32'h20, 32'hAA22_CC44, 1'b0);

        // Status registers update on the edge after their grant
        drive(1'b1, 1'b1, 4'hF, FLAG, 32'h1);
        drive(1'b1, 1'b1, 4'hF, RES, 32'h37);
        @(negedge clk);
        chk("t3_flag_set", flag0, 32'h1);
        chk("t3_result_not_yet", res0, 32'h0);
        idle();
        @(negedge clk);
        chk("t3_result_set", res0, 32'd55);
        read_chk("t3_flag_rd", FLAG, 32'h1, 1'b0);
        read_chk("t3_result_rd", RES, 32'd55, 1'b0);

        // Wait states on the second instance
        ws_run("t4_ws_write", 1'b1, 32'h40, 32'hCAFE_F00D, 32'd0);
        drive3(1'b1, 1'b0, 32'h40, 32'd0);
        repeat (2) begin
            @(negedge clk);
            chk("t4_abort_no_gnt", {31'd0, gnt3}, 32'd0);
        end
        drive3(1'b0, 1'b0, 32'd0, 32'd0);
        repeat (4) begin
            @(negedge clk);
            chk("t4_abort_no_gnt_idle", {31'd0, gnt3}, 32'd0);
            chk("t4_abort_no_rvalid", {31'd0, rvalid3}, 32'd0);
        end
        ws_run("t4_ws_restart_read", 1'b0, 32'h40, 32'd0, 32'hCAFE_F00D);

        // Unmapped accesses
        read_chk("t5_unmapped_rd", 32'h2000, BAD, 1'b1);
        drive(1'b1, 1'b1, 4'hF, 32'h2000, 32'h5555_5555);
        idle();
        @(negedge clk);
        chk("t5_unmapped_wr_err", {31'd0, err0}, 32'd1);
        chk("t5_unmapped_wr_rdata", rdata0, 32'd0);
        read_chk("t5_first_oob_word", 32'h400, BAD, 1'b1);
        read_chk("t5_last_ram_word_ok_flag", FLAG, 32'h1, 1'b0);
        read_chk("t5_ram_intact", 32'h10, 32'h0000_0037, 1'b0);

        // Define a pool of RAM words, then randomized back-to-back traffic
        for (int i = 0; i < 16; i++) drive(1'b1, 1'b1, 4'hF, 32'(i * 4), $urandom);
        drive(1'b1, 1'b1, 4'hF, 32'h3FC, $urandom);
        for (int i = 0; i < 400; i++) begin
            sel = int'($urandom_range(0, 9));
            case (sel)
                0, 1, 2, 3, 4, 5: a = 32'($urandom_range(0, 15) * 4 + $urandom_range(0, 3));
                6:       a = 32'h3FC;
                7:       a = FLAG;
                8:       a = RES;
                default: begin
                    case ($urandom_range(0, 3))
                        0:       a = 32'h400;
                        1:       a = 32'h2000;
                        2:       a = 32'h1008;
                        default: a = 32'hFFFF_FFFC;
                    endcase
                end
            endcase
            case ($urandom_range(0, 9))
                0:       b = 4'h0;
                1, 2, 3: b = 4'hF;
                default: b = 4'($urandom);
            endcase
            drive(($urandom_range(0, 9) < 7), 1'($urandom), b, a, $urandom);
        end
        idle();

        // Reset right after a grant suppresses the response
        drive(1'b1, 1'b1, 4'hF, 32'h30, 32'h1234_5678);
        drive(1'b1, 1'b1, 4'hF, FLAG, 32'h5);
        drive(1'b1, 1'b0, 4'hF, 32'h30, 32'd0);
        @(negedge clk);
        chk("t6_gnt_before_rst", {31'd0, gnt0}, 32'd1);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        req0 = 1'b0;
        @(negedge clk);
        chk("t6_no_rvalid", {31'd0, rvalid0}, 32'd0);
        chk("t6_flag_cleared", flag0, 32'd0);
        chk("t6_result_cleared", res0, 32'd0);
        chk("t6_rdata_cleared", rdata0, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        read_chk("t6_ram_survives", 32'h30, 32'h1234_5678, 1'b0);

        repeat (4) idle();
        @(negedge clk);
        chk("scoreboard_drained", 32'(sbq.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        checks++;
        errors++;
        $display("FAIL timeout: simulation exceeded time budget");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
